seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial bit-sequence detector: the generalised successor to the fixed 4-bit detector FSMs in the FSM library. The block samples a 1-bit serial stream qualified by a valid strobe and compares it against a compile-time pattern of length N. It emits a one-cycle registered match pulse and keeps a saturating match counter. Overlapping or non-overlapping detection is selected at run time. It sits between a serial receiver/deserialiser front end and control logic that reacts to framing or sync words.

## Interface
- N, default 4: pattern length in bits; legal range 2..32.
- PATTERN, default 4'b1001 (N bits): target sequence. The MSB is the first bit received and the LSB is the last.
- CNT_W, default 8: width of the match counter; legal range 1..32.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in_valid  input  1  qualifies `in`. Bits are consumed only when in_valid=1.
- in  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection; 0 = non-overlapping detection.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  one-cycle pulse, registered.
- match_cnt  output  CNT_W  saturating count of matches.
- fill  output  $clog2(N+1)  number of valid history bits currently held, 0..N; debug/observability.

## Operation
- State consists of: history shift register hist[N-1:0], fill counter, match register, match_cnt.
- On a rising edge with rst=1:
  - hist=0, fill=0, match=0, match_cnt=0.
  - All other inputs are ignored in that cycle.
- On an accepted bit (in_valid=1, rst=0):
  - next_hist = {hist[N-2:0], in}.
  - next_fill = min(fill+1, N).
  - hit = (next_fill==N) && (next_hist==PATTERN).
- Overlap mode (overlap=1):
  - hist=next_hist and fill=next_fill on every accepted bit, hit or not.
  - A suffix of one match can form the prefix of the next match.
- Non-overlap mode (overlap=0):
  - On hit, fill is set to 0. History bits from before the hit cannot contribute to a later match.
  - Otherwise the update is as in overlap mode.
- overlap is sampled per accepted bit. A change takes effect for the next accepted bit; no flush occurs.
- match is set to hit on an accepted bit and to 0 in every cycle with in_valid=0.
- match_cnt:
  - Increments by 1 on hit and saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 alone: match_cnt=0.
  - cnt_clr=1 in the same cycle as a hit: match_cnt=1. The event is not lost.
- in_valid=0: hist, fill and match_cnt hold.
- Illegal parameters (N<2, N>32, PATTERN width≠N) are rejected at elaboration.

## Timing
- Latency: match is asserted in the cycle immediately after the rising edge that accepted the last pattern bit. Equivalently, it is visible one edge after that bit was presented with in_valid=1.
- match_cnt updates on the same edge that sets match.
- Back-to-back matches are possible in overlap mode, e.g. for patterns of all 1s. The maximum rate is one match per accepted bit.
- In non-overlap mode the minimum spacing is N accepted bits between matches.
- Gaps in in_valid do not break a sequence. Bits are concatenated across idle cycles.
- rst asserted mid-sequence discards a partial history. The first possible match after reset requires N accepted bits after rst deasserts.
- There is no combinational path from inputs to outputs.

## Test plan
- Reset values: hold rst=1 for 2 cycles with random in/in_valid -> match=0, match_cnt=0, fill=0. After release, fill=0 until the first valid bit.
- Overlap: N=4, PATTERN=1001, overlap=1, stream 1001001 with in_valid=1 every cycle -> match pulses after bit 4 and after bit 7; match_cnt=2.
- Non-overlap: same stream with overlap=0 -> single pulse after bit 4; match_cnt=1; fill=3 after bit 7.
- Valid gaps: stream 1,0,0,1 with 3 idle cycles (in toggling) between each bit -> exactly one pulse, in the cycle after the 4th accepted bit; match is 0 during idle cycles.
- Saturation and clear:
  - CNT_W=2, PATTERN=11 (N=2), overlap=1, 6 consecutive 1s -> 5 hits; match_cnt sticks at 3.
  - cnt_clr asserted coincident with a hit -> match_cnt=1.
- Reset mid-sequence: feed 100, assert rst one cycle, then feed 1 -> no match. Then feed 1001 -> match with latency 1.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector for a compile-time N-bit pattern (MSB received first),
// with run-time overlap selection, registered match pulse and saturating match counter.
module seq_detector_param #(
  parameter int N       = 4,
  parameter     PATTERN = 4'b1001,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in,
  input  logic                       overlap,
  input  logic                       cnt_clr,
  output logic                       match,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(N+1)-1:0]     fill
);

  localparam int FW = $clog2(N+1);
  localparam logic [N-1:0]     PAT       = N'(PATTERN);
  localparam logic [FW-1:0]    FILL_FULL = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  generate
    if (N < 2 || N > 32) begin : g_bad_n
      $error("seq_detector_param: N must lie in 2..32");
    end
    if ($bits(PATTERN) != N) begin : g_bad_pattern
      $error("seq_detector_param: PATTERN width must equal N");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
      $error("seq_detector_param: CNT_W must lie in 1..32");
    end
  endgenerate

  logic [N-1:0]     hist_reg;
  logic [N-1:0]     hist_next;
  logic [FW-1:0]    fill_reg;
  logic [FW-1:0]    fill_next;
  logic             match_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             hit;

  // Newest bit enters at the LSB so the oldest held bit lines up with PATTERN's MSB.
  assign hist_next[0] = in;
  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_shift
      assign hist_next[gi] = hist_reg[gi-1];
    end
  endgenerate

  always_comb begin
    fill_next = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FW'(1);
    hit       = in_valid && (fill_next == FILL_FULL) && (hist_next == PAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg  <= '0;
      fill_reg  <= '0;
      match_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      match_reg <= hit;
      if (in_valid) begin
        hist_reg <= hist_next;
        // Emptying the fill count is enough to keep pre-hit bits out of the next match.
        fill_reg <= (hit && !overlap) ? '0 : fill_next;
      end
      if (cnt_clr) begin
        cnt_reg <= hit ? CNT_W'(1) : '0;
      end else if (hit && cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign match     = match_reg;
  assign match_cnt = cnt_reg;
  assign fill      = fill_reg;

endmodule
